// File: rtl/mem_arb2_if.sv
// rtl/mem_arb2_if.sv - client and memory control signals of the two-client memory arbiter
// The shared data bus mem_dq stays a plain inout port on the arbiter.
interface mem_arb2_if #(
    parameter int a_heigth = 4,
    parameter int d_width  = 4
);
    logic                req0;
    logic                req1;
    logic                we0;
    logic                we1;
    logic [a_heigth-1:0] addr0;
    logic [a_heigth-1:0] addr1;
    logic [d_width-1:0]  wdata0;
    logic [d_width-1:0]  wdata1;
    logic                gnt0;
    logic                gnt1;
    logic                rvalid0;
    logic                rvalid1;
    logic [d_width-1:0]  rdata0;
    logic [d_width-1:0]  rdata1;
    logic                mem_read;
    logic                mem_wr;
    logic [a_heigth-1:0] mem_addr;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_read, mem_wr, mem_addr
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_read, mem_wr, mem_addr
    );
endinterface

// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - two-client round-robin arbiter and sequencer for a single-port memory
// Owns the shared data bus direction; a read always ends with a TURN cycle before the next access.
module mem_arb2 #(
    parameter int a_heigth = 4,
    parameter int d_width  = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_arb2_if.slave          bus,
    inout  wire [d_width-1:0]  mem_dq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RDCAP = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                sel_q, sel_d;
    logic [a_heigth-1:0] addr_q, addr_d;
    logic [d_width-1:0]  wdata_q, wdata_d;
    logic [d_width-1:0]  rdata0_q, rdata1_q;
    logic                win_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            // Read data is taken off the bus at the edge that ends RDCAP.
            if (state_q == RDCAP) begin
                if (sel_q) rdata1_q <= mem_dq;
                else       rdata0_q <= mem_dq;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Under contention the client that did not win last time goes first.
                    sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = sel_d;
                    addr_d  = sel_d ? bus.addr1  : bus.addr0;
                    wdata_d = sel_d ? bus.wdata1 : bus.wdata0;
                    win_we  = sel_d ? bus.we1    : bus.we0;
                    state_d = win_we ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RDCAP;
            RDCAP:   state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0     = ((state_q == WR) || (state_q == RD)) && !sel_q;
    assign bus.gnt1     = ((state_q == WR) || (state_q == RD)) &&  sel_q;
    assign bus.rvalid0  = (state_q == TURN) && !sel_q;
    assign bus.rvalid1  = (state_q == TURN) &&  sel_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_wr   = (state_q == WR);
    assign bus.mem_read = (state_q == RD) || (state_q == RDCAP);
    assign bus.mem_addr = addr_q;

    assign mem_dq = (state_q == WR) ? wdata_q : {d_width{1'bz}};

endmodule

// File: tb/tb_mem_arb2.sv
// tb/tb_mem_arb2.sv - directed self-checking bench for mem_arb2 with a behavioural memory
module tb_mem_arb2;
    localparam int AW = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb2_if #(.a_heigth(AW), .d_width(DW)) bus ();
    wire [DW-1:0] mem_dq;

    mem_arb2 #(.a_heigth(AW), .d_width(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .mem_dq (mem_dq)
    );

    logic [DW-1:0] mem [16];
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= mem_dq;
    assign mem_dq = bus.mem_read ? mem[bus.mem_addr] : {DW{1'bz}};

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) check("rd_wr_excl", {31'd0, bus.mem_read & bus.mem_wr}, 32'd0);

    task automatic set_req(input int c, input logic on, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (c == 0) begin
            bus.req0 = on; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = on; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic wait_gnt(input int c, output int waited);
        logic g;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            g = (c == 0) ? bus.gnt0 : bus.gnt1;
        end while (!g && waited < 10);
        if (!g) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic write_txn(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w;
        set_req(c, 1'b1, 1'b1, a, d);
        wait_gnt(c, w);
        check("wr_latency", w, 1);
        check("wr_mem_wr", {31'd0, bus.mem_wr}, 1);
        check("wr_mem_read", {31'd0, bus.mem_read}, 0);
        check("wr_addr", {28'd0, bus.mem_addr}, {28'd0, a});
        check("wr_dq", {28'd0, mem_dq}, {28'd0, d});
        set_req(c, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic read_txn(input int c, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int w;
        set_req(c, 1'b1, 1'b0, a, '0);
        wait_gnt(c, w);
        check("rd_latency", w, 1);
        check("rd_mem_read", {31'd0, bus.mem_read}, 1);
        check("rd_mem_wr", {31'd0, bus.mem_wr}, 0);
        check("rd_addr", {28'd0, bus.mem_addr}, {28'd0, a});
        set_req(c, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rdcap_mem_read", {31'd0, bus.mem_read}, 1);
        check("rdcap_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
        @(negedge clk);
        check("turn_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, (c == 0) ? 32'd1 : 32'd2);
        check("turn_rdata", {28'd0, (c == 0) ? bus.rdata0 : bus.rdata1}, {28'd0, exp});
        check("turn_mem_read", {31'd0, bus.mem_read}, 0);
        @(negedge clk);
        check("idle_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        check("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
        check("rst_mem_ctl", {30'd0, bus.mem_read, bus.mem_wr}, 0);
        check("rst_mem_addr", {28'd0, bus.mem_addr}, 0);
        check("rst_rdata", {24'd0, bus.rdata1, bus.rdata0}, 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Single write then read-back by the other client
        write_txn(0, 4'd3, 4'hA);
        read_txn(1, 4'd3, 4'hA);

        // Contention: both clients hold write requests; grants alternate 0,1,0,1
        set_req(0, 1'b1, 1'b1, 4'd5, 4'h9);
        set_req(1, 1'b1, 1'b1, 4'd6, 4'hC);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("cont_gnt", {30'd0, bus.gnt1, bus.gnt0},
                  (i % 4 == 0) ? 32'd1 : ((i % 4 == 2) ? 32'd2 : 32'd0));
            if (i % 4 == 0) check("cont_dq0", {28'd0, mem_dq}, 32'h9);
            if (i % 4 == 2) check("cont_dq1", {28'd0, mem_dq}, 32'hC);
            if (i == 7) begin
                set_req(0, 1'b0, 1'b0, '0, '0);
                set_req(1, 1'b0, 1'b0, '0, '0);
            end
        end
        @(negedge clk);
        check("cont_end_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        read_txn(0, 4'd5, 4'h9);
        read_txn(1, 4'd6, 4'hC);

        // Fill and reverse readback
        for (int a = 0; a < 16; a++) write_txn(0, 4'(a), 4'(a));
        for (int a = 15; a >= 0; a--) read_txn(1, 4'(a), 4'(a));

        // Read by 0 with a write by 1 queued behind it
        set_req(0, 1'b1, 1'b0, 4'd2, 4'h0);
        set_req(1, 1'b1, 1'b1, 4'd2, 4'h7);
        @(negedge clk);
        check("q_rd_gnt", {30'd0, bus.gnt1, bus.gnt0}, 1);
        check("q_rd_read", {31'd0, bus.mem_read}, 1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("q_rdcap_wr", {31'd0, bus.mem_wr}, 0);
        @(negedge clk);
        check("q_turn_ctl", {30'd0, bus.mem_read, bus.mem_wr}, 0);
        check("q_turn_rvalid0", {31'd0, bus.rvalid0}, 1);
        check("q_turn_rdata0", {28'd0, bus.rdata0}, 32'h2);
        @(negedge clk);
        check("q_idle_wr", {31'd0, bus.mem_wr}, 0);
        check("q_idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        @(negedge clk);
        check("q_wr_gnt", {30'd0, bus.gnt1, bus.gnt0}, 2);
        check("q_wr_mem_wr", {31'd0, bus.mem_wr}, 1);
        check("q_wr_dq", {28'd0, mem_dq}, 32'h7);
        check("q_wr_addr", {28'd0, bus.mem_addr}, 32'h2);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        read_txn(0, 4'd2, 4'h7);

        // Reset during RDCAP abandons the read and restores priority to client 0
        set_req(0, 1'b1, 1'b0, 4'd4, 4'h0);
        @(negedge clk);
        check("r6_gnt", {30'd0, bus.gnt1, bus.gnt0}, 1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("r6_rdcap", {31'd0, bus.mem_read}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r6_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
        check("r6_mem_read", {31'd0, bus.mem_read}, 0);
        check("r6_rdata0", {28'd0, bus.rdata0}, 0);
        set_req(0, 1'b1, 1'b1, 4'd8, 4'h1);
        set_req(1, 1'b1, 1'b1, 4'd9, 4'h2);
        @(negedge clk);
        check("r6_cont_first", {30'd0, bus.gnt1, bus.gnt0}, 1);
        check("r6_cont_dq", {28'd0, mem_dq}, 32'h1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("r6_cont_idle", {30'd0, bus.gnt1, bus.gnt0}, 0);
        @(negedge clk);
        check("r6_cont_second", {30'd0, bus.gnt1, bus.gnt0}, 2);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
